mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
- Sequences data-memory accesses issued by the MEM stage onto an external 16-bit asynchronous SRAM.
- Sits between the EXE/MEM pipeline register outputs (ALU result as address, store value, read/write enables) and the SRAM pins.
- Each 32-bit word access is split into two half-word phases with programmable wait states.
- Drives `ready`; the pipeline freezes all stage registers while `ready` is low.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM half-word address width.
- WAIT_CYCLES, 1: extra cycles per half-word phase, range 0..7.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- mem_r_en  input  1  load request, held until ready
- mem_w_en  input  1  store request, held until ready
- addr  input  32  byte address (ALU result)
- wdata  input  32  store value
- rdata  output  32  load data, valid while ready is high in DONE
- ready  output  1  combinational; low freezes pipeline
- addr_err  output  1  registered one-cycle pulse on misaligned or out-of-range request
- sram_addr  output  SRAM_AW  half-word address
- sram_wdata  output  16  write data to pad
- sram_rdata  input  16  read data from pad
- sram_dq_oe  output  1  pad output enable
- sram_we_n  output  1  write strobe, active low
- sram_oe_n  output  1  read enable, active low

Behaviour:
- Reset (async):
  - state=IDLE, cnt=0, rdata=0, addr_err=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_wdata=0.
  - Reset mid-access aborts immediately and drops strobes in the same cycle. The partial write is tolerated.
- Request: req = mem_r_en | mem_w_en. If both are high, write wins (treated as store).
- Address map:
  - off = addr - BASE_ADDR.
  - Word index = off[SRAM_AW:2].
  - sram_addr = {word index, half}, where half=0 is the low half-word [15:0] and half=1 is the high half-word [31:16].
- Legal request:
  - addr[1:0]==0, and
  - BASE_ADDR <= addr < BASE_ADDR + 2^(SRAM_AW+1).
- Illegal request seen in IDLE:
  - No SRAM activity, state stays IDLE.
  - addr_err pulses the next cycle.
  - ready stays high, so the pipeline does not freeze.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE, legal req: latch address, wdata and op (read/write); cnt=0; go to LOW. ready=0 in this cycle.
  - LOW: sram_addr={idx,0}.
    - Write: sram_dq_oe=1, sram_wdata=wdata[15:0], sram_we_n=0.
    - Read: sram_oe_n=0; on the last phase cycle (cnt==WAIT_CYCLES) capture sram_rdata into rdata[15:0].
    - cnt increments each cycle; at cnt==WAIT_CYCLES, reset cnt and go to HIGH.
  - HIGH: same as LOW, using half=1 and bits [31:16]; go to DONE.
  - DONE: all strobes inactive; ready=1; unconditionally return to IDLE. The pipeline advances on this edge.
- Strobes are registered outputs.
  - we_n rises at the phase end while address and data are still stable, on the transition edge.
  - Between LOW and HIGH, we_n deasserts for zero cycles. Back-to-back strobes are acceptable for the target SRAM.
- ready: high in IDLE with no legal req, and high in DONE. Low in IDLE with a legal req, and in LOW and HIGH.
- Latency: ready is low for 1 + 2*(WAIT_CYCLES+1) cycles per access (5 at the default).
- Request inputs are ignored outside IDLE, since the pipeline is frozen and holds them stable.
- Back-to-back accesses: DONE → IDLE → LOW gives one IDLE cycle with ready low between accesses.
- rdata holds its last value until the next read overwrites it.

Decomposition:
- Shared package `mem_ctrl_pkg`:
  - State enum {IDLE, LOW, HIGH, DONE}.
  - Defaults for BASE_ADDR and SRAM_AW.
  - Half-word index constants.
- One natural sub-module, `sram_phase_timer`: the wait-state counter. Inputs start and WAIT_CYCLES; output last.
- The FSM and pad drive stay in the top module.

Test Plan:
- Store addr=1024, wdata=0xDEADBEEF, W=1 → LOW: sram_addr=0, wdata 0xBEEF, we_n low 2 cycles; HIGH: sram_addr=1, 0xDEAD; ready low 5 cycles then high 1.
- Load addr=1028, SRAM model returns 0x5678 at address 2 and 0x1234 at address 3 → rdata=0x12345678 in DONE; oe_n low 4 cycles; we_n never low.
- Load addr=1026 (misaligned) and load addr=1000 (below base) → addr_err pulse each; ready never low; no strobes.
- mem_r_en=mem_w_en=1 at addr=1032 → write performed to half-word addresses 4 and 5; oe_n stays high.
- Assert rst during HIGH of a store → same cycle: we_n=1, dq_oe=0, state IDLE; next load to 1036 completes normally.
- W=0 then W=3 → ready low 3 and 9 cycles respectively; two back-to-back loads each complete, with one IDLE cycle between them.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int unsigned DEF_SRAM_AW   = 18;

  // Wait-state counter width: covers WAIT_CYCLES 0..7.
  localparam int unsigned CNT_W = 3;

  // Half-word select appended as the SRAM address LSB.
  localparam logic HALF_LO = 1'b0;  // word bits [15:0]
  localparam logic HALF_HI = 1'b1;  // word bits [31:16]

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side bus of the SRAM controller: request, address, data, ready.
// Latency: n/a (wires only).
// Backpressure: ready low asks the master to hold every request signal stable.
// master: MEM stage (drives enables/addr/wdata); slave: controller (drives rdata/ready/addr_err).
interface mem_sram_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_err;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
    input  rdata, ready, addr_err
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
    output rdata, ready, addr_err
  );
endinterface

// File: rtl/mem_sram_ctrl_phase_timer.sv
// Wait-state counter for one half-word phase; last flags the final phase cycle.
// Latency: last is combinational from the count; count updates each clk.
// Backpressure: none; start clears, run advances and wraps to 0 after last.
// Ports: clk, rst (async high), start, run, wait_cycles[2:0] in; last out.
module sram_phase_timer
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [CNT_W-1:0] wait_cycles,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == wait_cycles);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run) begin
      // Wrap at the phase end so the next phase starts from zero.
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Splits each 32-bit MEM-stage access into low/high half-word phases on a 16-bit async SRAM.
// Latency: ready low for 1 + 2*(WAIT_CYCLES+1) cycles per legal access; illegal requests never stall.
// Backpressure: ready low freezes the pipeline; request inputs are only sampled in IDLE.
// Ports: clk, rst (async high); bus (slave modport); sram_addr/wdata/dq_oe/we_n/oe_n out, sram_rdata in.
module mem_sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_sram_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [31:0]      BASE   = 32'(BASE_ADDR);
  localparam logic [31:0]      SPAN   = 32'(1) << (SRAM_AW + 1);
  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [SRAM_AW-2:0] idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_q, wr_d;
  logic               addr_err_q, addr_err_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        sram_wdata_q, sram_wdata_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;

  logic [31:0] off;
  logic        req, legal, ready, phase_last;

  assign off   = bus.addr - BASE;
  assign req   = bus.mem_r_en | bus.mem_w_en;
  assign legal = (bus.addr[1:0] == 2'b00) && (bus.addr >= BASE) && (off < SPAN);

  sram_phase_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (state_q == IDLE),
    .run         ((state_q == LOW) || (state_q == HIGH)),
    .wait_cycles (WAIT_C),
    .last        (phase_last)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    addr_err_d = 1'b0;
    ready      = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (legal) begin
            ready   = 1'b0;
            state_d = LOW;
            idx_d   = off[SRAM_AW:2];
            wdata_d = bus.wdata;
            wr_d    = bus.mem_w_en;  // store wins when both enables are set
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      LOW: begin
        if (phase_last) begin
          state_d = HIGH;
          if (!wr_q) rdata_d[15:0] = sram_rdata;
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_d = DONE;
          if (!wr_q) rdata_d[31:16] = sram_rdata;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pad controls are registered and decoded from the next state, so they
    // line up with the phase itself. LOW->HIGH keeps we_n low (no gap), and
    // we_n rises on the HIGH->DONE edge while address/data are still held.
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    dq_oe_d      = 1'b0;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    if ((state_d == LOW) || (state_d == HIGH)) begin
      sram_addr_d  = {idx_d, (state_d == HIGH) ? HALF_HI : HALF_LO};
      sram_wdata_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
      dq_oe_d      = wr_d;
      we_n_d       = !wr_d;
      oe_n_d       = wr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
      addr_err_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rdata_q      <= rdata_d;
      addr_err_q   <= addr_err_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      dq_oe_q      <= dq_oe_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = ready;
  assign bus.addr_err = addr_err_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_we_n    = we_n_q;
  assign sram_oe_n    = oe_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: three instances (WAIT_CYCLES 1, 0, 3) against a word-level reference.
// Latency: n/a.
// Backpressure: requests held until ready is seen high.
module tb_mem_sram_ctrl;

  localparam int N  = 3;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         r_en, w_en;
  logic [N-1:0][31:0]   addr_i, wdata_i, rdata_o;
  logic [N-1:0]         ready_o, err_o, dq_oe_o, we_n_o, oe_n_o;
  logic [N-1:0][AW-1:0] saddr_o;
  logic [N-1:0][15:0]   swd_o, srd_i;

  function automatic int unsigned wait_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    mem_sram_ctrl_if bus ();
    assign bus.mem_r_en = r_en[gi];
    assign bus.mem_w_en = w_en[gi];
    assign bus.addr     = addr_i[gi];
    assign bus.wdata    = wdata_i[gi];
    assign rdata_o[gi]  = bus.rdata;
    assign ready_o[gi]  = bus.ready;
    assign err_o[gi]    = bus.addr_err;

    mem_sram_ctrl #(
      .BASE_ADDR   (1024),
      .SRAM_AW     (AW),
      .WAIT_CYCLES ((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_addr  (saddr_o[gi]),
      .sram_wdata (swd_o[gi]),
      .sram_rdata (srd_i[gi]),
      .sram_dq_oe (dq_oe_o[gi]),
      .sram_we_n  (we_n_o[gi]),
      .sram_oe_n  (oe_n_o[gi])
    );
  end

  // ---------------- SRAM pad model (half-word granular) ----------------
  logic [15:0] sram_mem [int unsigned];

  function automatic int unsigned key(input int i, input int unsigned a);
    return (int'(i) << 20) | a;
  endfunction

  // Contents of never-written SRAM locations.
  function automatic logic [15:0] dflt(input int unsigned k);
    return 16'(k * 32'd40503) ^ 16'h5A5A;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!we_n_o[i]) sram_mem[key(i, saddr_o[i])] = swd_o[i];
      srd_i[i] = sram_mem.exists(key(i, saddr_o[i])) ? sram_mem[key(i, saddr_o[i])] : dflt(key(i, saddr_o[i]));
    end
  end

  // ---------------- reference model (32-bit word granular) ----------------
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_rd [N];

  function automatic logic [31:0] ref_read(input int i, input int unsigned w);
    if (ref_mem.exists(key(i, w))) return ref_mem[key(i, w)];
    return {dflt(key(i, 2 * w + 1)), dflt(key(i, 2 * w))};
  endfunction

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access: drive request, count stall and strobe cycles, check against the rules.
  task automatic access(input int i, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit b2b, input string tag);
    int unsigned wc, widx;
    logic legal, is_wr, is_rd;
    int lo, wen, oen, dqn;
    bit done;
    logic [AW-1:0] wa_first, wa_last, ra_first, ra_last;
    logic [15:0] wd_first, wd_last;
    wc    = wait_of(i);
    legal = (r || w) && (a[1:0] == 2'b00) && (a >= 32'd1024) && ((a - 32'd1024) < 32'h0008_0000);
    is_wr = legal && w;
    is_rd = legal && !w && r;
    widx  = (a - 32'd1024) >> 2;
    lo = 0; wen = 0; oen = 0; dqn = 0; done = 1'b0;
    wa_first = '0; wa_last = '0; ra_first = '0; ra_last = '0; wd_first = '0; wd_last = '0;
    r_en[i] = r; w_en[i] = w; addr_i[i] = a; wdata_i[i] = d;
    if (b2b) @(negedge clk);
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (!we_n_o[i]) begin
        if (wen == 0) begin wa_first = saddr_o[i]; wd_first = swd_o[i]; end
        wa_last = saddr_o[i]; wd_last = swd_o[i]; wen++;
      end
      if (!oe_n_o[i]) begin
        if (oen == 0) ra_first = saddr_o[i];
        ra_last = saddr_o[i]; oen++;
      end
      if (dq_oe_o[i]) dqn++;
      if (ready_o[i]) done = 1'b1;
      else begin lo++; @(negedge clk); end
    end
    if (!done) chk({tag, " ready_timeout"}, 32'd0, 32'd1);
    chk({tag, " ready_low_cycles"}, 32'(lo), legal ? 32'(1 + 2 * (wc + 1)) : 32'd0);
    chk({tag, " we_low_cycles"},    32'(wen), is_wr ? 32'(2 * (wc + 1)) : 32'd0);
    chk({tag, " dq_oe_cycles"},     32'(dqn), is_wr ? 32'(2 * (wc + 1)) : 32'd0);
    chk({tag, " oe_low_cycles"},    32'(oen), is_rd ? 32'(2 * (wc + 1)) : 32'd0);
    if (is_wr) begin
      chk({tag, " wr_addr_lo"}, 32'(wa_first), 32'({widx[AW-2:0], 1'b0}));
      chk({tag, " wr_data_lo"}, 32'(wd_first), 32'(d[15:0]));
      chk({tag, " wr_addr_hi"}, 32'(wa_last),  32'({widx[AW-2:0], 1'b1}));
      chk({tag, " wr_data_hi"}, 32'(wd_last),  32'(d[31:16]));
      ref_mem[key(i, widx)] = d;
    end
    if (is_rd) begin
      chk({tag, " rd_addr_lo"}, 32'(ra_first), 32'({widx[AW-2:0], 1'b0}));
      chk({tag, " rd_addr_hi"}, 32'(ra_last),  32'({widx[AW-2:0], 1'b1}));
      last_rd[i] = ref_read(i, widx);
    end
    chk({tag, " rdata"}, rdata_o[i], last_rd[i]);
  endtask

  // Drop the request after the next edge, then check addr_err for that edge.
  task automatic idle_chk(input int i, input logic exp_err, input string tag);
    @(posedge clk);
    #1;
    r_en[i] = 1'b0; w_en[i] = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, " addr_err"}, 32'(err_o[i]), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, b;
    int unsigned kind;
    logic r, w;
    r_en = '0; w_en = '0; addr_i = '0; wdata_i = '0;
    for (int i = 0; i < N; i++) last_rd[i] = '0;
    sram_mem[key(0, 2)] = 16'h5678;
    sram_mem[key(0, 3)] = 16'h1234;
    ref_mem[key(0, 1)]  = 32'h1234_5678;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst ready",    32'(ready_o[i]), 32'd1);
      chk("rst we_n",     32'(we_n_o[i]),  32'd1);
      chk("rst oe_n",     32'(oe_n_o[i]),  32'd1);
      chk("rst dq_oe",    32'(dq_oe_o[i]), 32'd0);
      chk("rst addr",     32'(saddr_o[i]), 32'd0);
      chk("rst wdata",    32'(swd_o[i]),   32'd0);
      chk("rst rdata",    rdata_o[i],      32'd0);
      chk("rst addr_err", 32'(err_o[i]),   32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed, WAIT_CYCLES=1
    access(0, 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, "st1024"); idle_chk(0, 1'b0, "st1024");
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "ld1028");
    chk("ld1028 value", rdata_o[0], 32'h1234_5678);
    idle_chk(0, 1'b0, "ld1028");
    access(0, 1'b1, 1'b0, 32'd1026, 32'h0, 1'b0, "ld1026"); idle_chk(0, 1'b1, "ld1026");
    idle_chk(0, 1'b0, "ld1026 pulse_end");
    access(0, 1'b1, 1'b0, 32'd1000, 32'h0, 1'b0, "ld1000"); idle_chk(0, 1'b1, "ld1000");
    idle_chk(0, 1'b0, "ld1000 pulse_end");
    access(0, 1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, 1'b0, "rw1032"); idle_chk(0, 1'b0, "rw1032");
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, "ld1032");
    chk("ld1032 value", rdata_o[0], 32'hCAFE_F00D);
    idle_chk(0, 1'b0, "ld1032");

    // Reset during HIGH of a store to word 244
    r_en[0] = 1'b0; w_en[0] = 1'b1; addr_i[0] = 32'd2000; wdata_i[0] = 32'hA5A5_5A5A;
    repeat (3) @(posedge clk);
    #2;
    chk("abort in_high we_n", 32'(we_n_o[0]), 32'd0);
    chk("abort in_high addr", 32'(saddr_o[0]), 32'h1E9);
    rst = 1'b1; w_en[0] = 1'b0;
    #1;
    chk("abort we_n",  32'(we_n_o[0]),  32'd1);
    chk("abort dq_oe", 32'(dq_oe_o[0]), 32'd0);
    chk("abort idle",  32'(ready_o[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) last_rd[i] = '0;
    access(0, 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, "ld1036"); idle_chk(0, 1'b0, "ld1036");

    // WAIT_CYCLES=0 and 3: store, then two back-to-back loads
    for (int i = 1; i < N; i++) begin
      access(i, 1'b0, 1'b1, 32'd1040, 32'h0BAD_F00D, 1'b0, "wx st"); idle_chk(i, 1'b0, "wx st");
      access(i, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, "wx ld_a");
      access(i, 1'b1, 1'b0, 32'd1044, 32'h0, 1'b1, "wx ld_b"); idle_chk(i, 1'b0, "wx ld_b");
    end

    // Randomized traffic on every instance
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < 25; t++) begin
        kind = $urandom_range(0, 9);
        b    = 32'd1024 + 32'd4 * (32'd1024 + 32'($urandom_range(0, 7)));
        d    = $urandom;
        r    = 1'($urandom_range(0, 1));
        w    = 1'($urandom_range(0, 1));
        if (!r && !w) r = 1'b1;
        if (kind <= 2) begin
          case (kind)
            0:       a = b + 32'($urandom_range(1, 3));
            1:       a = 32'd1024 + 32'h0008_0000 + 32'd4 * 32'($urandom_range(0, 100));
            default: a = 32'd4 * 32'($urandom_range(0, 255));
          endcase
          access(i, r, w, a, d, 1'b0, "rnd bad"); idle_chk(i, 1'b1, "rnd bad");
          idle_chk(i, 1'b0, "rnd bad pulse_end");
        end else begin
          access(i, r, w, b, d, 1'b0, "rnd ok");
          if (kind >= 7) begin
            b = 32'd1024 + 32'd4 * (32'd1024 + 32'($urandom_range(0, 7)));
            access(i, 1'b1, 1'b0, b, 32'h0, 1'b1, "rnd b2b");
          end
          idle_chk(i, 1'b0, "rnd ok");
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
